ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for one `ram_simple` instance (single port, synchronous read, 1-cycle read latency, DATA_WIDTH/ADDR_WIDTH parameterised).
- Presents two independent valid/ready request channels (A, B) and two valid/ready read-response channels.
- Drives the RAM's we/addr/data_in and captures its data_out into per-port response registers.
- Sits between two bus masters (e.g. a DMA engine and a CPU-side port) and the shared RAM.

Parameters:
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 8, RAM address width; RAM depth is 2**ADDR_WIDTH.

Ports:
- clk, input, 1, single clock; all state updates on its rising edge.
- rst, input, 1, asynchronous active-high reset.
- a_req_valid, input, 1, requester A has a request.
- a_req_ready, output, 1, A's request is accepted this cycle.
- a_req_we, input, 1, 1 = write, 0 = read.
- a_req_addr, input, ADDR_WIDTH, A address.
- a_req_wdata, input, DATA_WIDTH, A write data.
- a_rsp_valid, output, 1, A read data is available.
- a_rsp_ready, input, 1, A consumes its response.
- a_rsp_rdata, output, DATA_WIDTH, A read data.
- b_req_valid, b_req_ready, b_req_we, b_req_addr, b_req_wdata, b_rsp_valid, b_rsp_ready, b_rsp_rdata: identical to the A ports, for requester B.
- ram_we, output, 1, to RAM `we`.
- ram_addr, output, ADDR_WIDTH, to RAM `addr`.
- ram_wdata, output, DATA_WIDTH, to RAM `data_in`.
- ram_rdata, input, DATA_WIDTH, from RAM `data_out` (registered in RAM).

Behaviour:
- Reset (async, rst=1): pend_a, pend_b, a_rsp_valid, b_rsp_valid, a_rsp_rdata, b_rsp_rdata all clear to 0. Round-robin pointer resets to "A preferred". ram_we=0, ram_addr=0, ram_wdata=0, req_ready=0.
- Reset mid-operation: in-flight reads and held responses are discarded with no response. The RAM contents are not touched.
- Eligibility, per port x:
  - elig_x = x_req_valid && (x_req_we || (!pend_x && !(x_rsp_valid && !x_rsp_ready))).
  - Writes are never blocked by response state.
  - A read is blocked while that port has a read in flight, or an un-popped response.
- Arbitration (combinational, same cycle):
  - Only one eligible port: it is granted.
  - Both eligible: the port not granted last time wins.
  - Pointer updates on every accepted request (x_req_valid && x_req_ready) to prefer the other port next.
- x_req_ready = granted to x. Requesters hold valid, we, addr and wdata stable until ready.
- RAM drive:
  - While a grant exists: ram_we = granted we, ram_addr = granted addr, ram_wdata = granted wdata.
  - With no grant: ram_we=0, ram_addr=0, ram_wdata=0.
- Read pipeline, read accepted from port x at edge k:
  - pend_x set at edge k; RAM updates data_out at edge k.
  - At edge k+1: x_rsp_rdata <= ram_rdata, x_rsp_valid <= 1, pend_x <= 0.
  - Read latency: rsp_valid rises 2 edges after acceptance.
  - Ports are independent: the other port may issue a read or write at edge k+1 without corrupting the capture, which uses the pre-edge data_out.
- Response pop:
  - x_rsp_valid && x_rsp_ready at an edge clears x_rsp_valid, unless a capture for x happens on the same edge, in which case valid stays 1 with new data.
  - rsp_rdata holds its value while valid && !ready.
- Throughput:
  - A single port can issue one read every 2 cycles; writes every cycle.
  - With both ports busy, reads from the two ports interleave at 1 access per cycle.
- Writes produce no response. A write followed next cycle by a read of the same address (either port) returns the new data.

Test Plan:
- Reset, then A writes addr 0x10 = 0x5A, then A reads 0x10 with a_rsp_ready=1 -> a_rsp_valid high exactly 2 edges after read acceptance, a_rsp_rdata=0x5A, b_rsp_valid stays 0.
- A and B both hold valid reads (0x01, 0x02) continuously after reset -> grants A, B, A, B... on successive cycles when eligible; each response carries the correct data; neither port waits more than 1 cycle once eligible.
- A issues a read with a_rsp_ready=0 for 5 cycles, then issues a second read -> a_req_ready stays 0 until a_rsp_ready=1, a_rsp_rdata stable meanwhile, while B writes are accepted every cycle.
- Same cycle: B writes 0x20 = 0xC3 and A reads 0x20; B was last granted -> A is granted first and returns the old data; the next A read returns 0xC3.
- rst asserted asynchronously one cycle after a read acceptance -> pend and rsp_valid are 0 immediately, no response ever appears, and a subsequent read of the same address returns the stored data.
- Back-to-back A reads of addresses 0xFF then 0x00 (address wrap), with a_rsp_ready tied 1 -> two responses in order, one every 2 cycles, with the correct data.

Source files
------------

// File: rtl/ram_arbiter.sv
// Round-robin arbiter that shares one single-port synchronous RAM between two
// valid/ready requesters, returning read data through per-port response registers.
module ram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic                  a_req_we,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [DATA_WIDTH-1:0] a_req_wdata,
    output logic                  a_rsp_valid,
    input  logic                  a_rsp_ready,
    output logic [DATA_WIDTH-1:0] a_rsp_rdata,

    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic                  b_req_we,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic [DATA_WIDTH-1:0] b_req_wdata,
    output logic                  b_rsp_valid,
    input  logic                  b_rsp_ready,
    output logic [DATA_WIDTH-1:0] b_rsp_rdata,

    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic {
        PREFER_A = 1'b0,
        PREFER_B = 1'b1
    } rr_state_t;

    rr_state_t rr_state;
    rr_state_t rr_next;

    logic pend_a;
    logic pend_b;
    logic elig_a;
    logic elig_b;
    logic grant_a;
    logic grant_b;

    // A read waits until the port has nothing in flight and no unconsumed response.
    assign elig_a = a_req_valid && (a_req_we || (!pend_a && !(a_rsp_valid && !a_rsp_ready)));
    assign elig_b = b_req_valid && (b_req_we || (!pend_b && !(b_rsp_valid && !b_rsp_ready)));

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst) begin
            if (elig_a && elig_b) begin
                grant_a = (rr_state == PREFER_A);
                grant_b = (rr_state == PREFER_B);
            end else begin
                grant_a = elig_a;
                grant_b = elig_b;
            end
        end
    end

    assign a_req_ready = grant_a;
    assign b_req_ready = grant_b;

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (grant_a) begin
            ram_we    = a_req_we;
            ram_addr  = a_req_addr;
            ram_wdata = a_req_wdata;
        end else if (grant_b) begin
            ram_we    = b_req_we;
            ram_addr  = b_req_addr;
            ram_wdata = b_req_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_state <= PREFER_A;
        end else begin
            rr_state <= rr_next;
        end
    end

    always_comb begin
        rr_next = rr_state;
        if (grant_a) begin
            rr_next = PREFER_B;
        end else if (grant_b) begin
            rr_next = PREFER_A;
        end
    end

    // Capture samples ram_rdata from before this edge, so the other port may
    // use the RAM in the same cycle without disturbing it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_a      <= 1'b0;
            a_rsp_valid <= 1'b0;
            a_rsp_rdata <= '0;
        end else begin
            pend_a <= grant_a && !a_req_we;
            if (pend_a) begin
                a_rsp_valid <= 1'b1;
                a_rsp_rdata <= ram_rdata;
            end else if (a_rsp_ready) begin
                a_rsp_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_b      <= 1'b0;
            b_rsp_valid <= 1'b0;
            b_rsp_rdata <= '0;
        end else begin
            pend_b <= grant_b && !b_req_we;
            if (pend_b) begin
                b_rsp_valid <= 1'b1;
                b_rsp_rdata <= ram_rdata;
            end else if (b_rsp_ready) begin
                b_rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed vector table, reset-during-read sequence and
// randomized traffic checked against a queue-based transaction model.
module tb_ram_arbiter;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int NV = 32;

    logic clk = 1'b0;
    logic rst;

    logic          a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready;
    logic [AW-1:0] a_req_addr;
    logic [DW-1:0] a_req_wdata, a_rsp_rdata;
    logic          b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready;
    logic [AW-1:0] b_req_addr;
    logic [DW-1:0] b_req_wdata, b_rsp_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
        .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
        .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rsp_rdata(a_rsp_rdata),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
        .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
        .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_rdata(b_rsp_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        return 8'(i) ^ 8'h96;
    endfunction

    // ram_simple stand-in: registered read, write-through on we
    initial begin
        for (int i = 0; i < (1<<AW); i++) mem[i] <= init_val(i);
    end

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // Reference model: each port owns an ordered list of responses, each becoming
    // visible two cycles after its request was accepted.
    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    rsp_t          q_a[$];
    rsp_t          q_b[$];
    logic [DW-1:0] mmem [0:(1<<AW)-1];
    bit            mmem_ready = 1'b0;
    bit            last_b = 1'b1;
    int            cyc = 0;

    function automatic bit shown(input rsp_t q[$], input int now);
        return (q.size() > 0) && (q[0].due <= now);
    endfunction

    function automatic bit can_go(input logic v, input logic we, input logic rr,
                                  input rsp_t q[$], input int now);
        if (!v) return 1'b0;
        if (we) return 1'b1;
        return (q.size() == 0) || (q.size() == 1 && shown(q, now) && rr);
    endfunction

    function automatic void pick(output bit ga, output bit gb);
        bit ea, eb;
        ea = can_go(a_req_valid, a_req_we, a_rsp_ready, q_a, cyc);
        eb = can_go(b_req_valid, b_req_we, b_rsp_ready, q_b, cyc);
        if (ea && eb) begin
            ga = last_b;
            gb = !last_b;
        end else begin
            ga = ea;
            gb = eb;
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        bit ga, gb;
        if (rst) begin
            q_a.delete();
            q_b.delete();
            last_b = 1'b1;
            if (!mmem_ready) begin
                for (int i = 0; i < (1<<AW); i++) mmem[i] = init_val(i);
                mmem_ready = 1'b1;
            end
        end else begin
            pick(ga, gb);
            if (shown(q_a, cyc) && a_rsp_ready) void'(q_a.pop_front());
            if (shown(q_b, cyc) && b_rsp_ready) void'(q_b.pop_front());
            if (ga) begin
                if (a_req_we) mmem[a_req_addr] = a_req_wdata;
                else q_a.push_back('{data: mmem[a_req_addr], due: cyc + 2});
                last_b = 1'b0;
            end
            if (gb) begin
                if (b_req_we) mmem[b_req_addr] = b_req_wdata;
                else q_b.push_back('{data: mmem[b_req_addr], due: cyc + 2});
                last_b = 1'b1;
            end
            cyc++;
        end
    end

    typedef struct {
        logic          av, awe;
        logic [AW-1:0] aaddr;
        logic [DW-1:0] awdata;
        logic          arr;
        logic          bv, bwe;
        logic [AW-1:0] baddr;
        logic [DW-1:0] bwdata;
        logic          brr;
        logic          exp_ar, exp_br, exp_av;
        logic [DW-1:0] exp_ad;
        logic          exp_bv;
        logic [DW-1:0] exp_bd;
    } vec_t;

    vec_t vecs [NV];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        a_req_valid = v.av;  a_req_we = v.awe;  a_req_addr = v.aaddr;  a_req_wdata = v.awdata;
        a_rsp_ready = v.arr;
        b_req_valid = v.bv;  b_req_we = v.bwe;  b_req_addr = v.baddr;  b_req_wdata = v.bwdata;
        b_rsp_ready = v.brr;
    endtask

    initial begin
        bit ga, gb, a_acc, b_acc;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;

        // A: v we addr wdata rr | B: v we addr wdata rr | a_ready b_ready a_val a_data b_val b_data
        vecs[0]  = '{1,1,'h10,'h5A,1, 0,0,'h00,'h00,1, 1,0,0,'h00,0,'h00};
        vecs[1]  = '{1,0,'h10,'h00,1, 0,0,'h00,'h00,1, 1,0,0,'h00,0,'h00};
        vecs[2]  = '{0,0,'h00,'h00,1, 0,0,'h00,'h00,1, 0,0,0,'h00,0,'h00};
        vecs[3]  = '{0,0,'h00,'h00,1, 0,0,'h00,'h00,1, 0,0,1,'h5A,0,'h00};
        vecs[4]  = '{0,0,'h00,'h00,1, 0,0,'h00,'h00,1, 0,0,0,'h00,0,'h00};
        vecs[5]  = '{1,0,'h01,'h00,1, 1,0,'h02,'h00,1, 0,1,0,'h00,0,'h00};
        vecs[6]  = '{1,0,'h01,'h00,1, 1,0,'h02,'h00,1, 1,0,0,'h00,0,'h00};
        vecs[7]  = '{1,0,'h01,'h00,1, 1,0,'h02,'h00,1, 0,1,0,'h00,1,'h94};
        vecs[8]  = '{1,0,'h01,'h00,1, 1,0,'h02,'h00,1, 1,0,1,'h97,0,'h00};
        vecs[9]  = '{1,0,'h01,'h00,1, 1,0,'h02,'h00,1, 0,1,0,'h00,1,'h94};
        vecs[10] = '{0,0,'h00,'h00,1, 0,0,'h00,'h00,1, 0,0,1,'h97,0,'h00};
        vecs[11] = '{0,0,'h00,'h00,1, 0,0,'h00,'h00,1, 0,0,0,'h00,1,'h94};
        vecs[12] = '{1,0,'h20,'h00,1, 1,1,'h20,'hC3,1, 1,0,0,'h00,0,'h00};
        vecs[13] = '{1,0,'h20,'h00,1, 1,1,'h20,'hC3,1, 0,1,0,'h00,0,'h00};
        vecs[14] = '{1,0,'h20,'h00,1, 0,0,'h00,'h00,1, 1,0,1,'hB6,0,'h00};
        vecs[15] = '{0,0,'h00,'h00,1, 0,0,'h00,'h00,1, 0,0,0,'h00,0,'h00};
        vecs[16] = '{0,0,'h00,'h00,1, 0,0,'h00,'h00,1, 0,0,1,'hC3,0,'h00};
        vecs[17] = '{1,0,'hFF,'h00,1, 0,0,'h00,'h00,1, 1,0,0,'h00,0,'h00};
        vecs[18] = '{1,0,'h00,'h00,1, 0,0,'h00,'h00,1, 0,0,0,'h00,0,'h00};
        vecs[19] = '{1,0,'h00,'h00,1, 0,0,'h00,'h00,1, 1,0,1,'h69,0,'h00};
        vecs[20] = '{0,0,'h00,'h00,1, 0,0,'h00,'h00,1, 0,0,0,'h00,0,'h00};
        vecs[21] = '{0,0,'h00,'h00,1, 0,0,'h00,'h00,1, 0,0,1,'h96,0,'h00};
        vecs[22] = '{1,0,'h10,'h00,0, 1,1,'h30,'h11,1, 0,1,0,'h00,0,'h00};
        vecs[23] = '{1,0,'h10,'h00,0, 1,1,'h31,'h22,1, 1,0,0,'h00,0,'h00};
        vecs[24] = '{1,0,'h40,'h00,0, 1,1,'h32,'h33,1, 0,1,0,'h00,0,'h00};
        vecs[25] = '{1,0,'h40,'h00,0, 1,1,'h33,'h44,1, 0,1,1,'h5A,0,'h00};
        vecs[26] = '{1,0,'h40,'h00,0, 1,1,'h34,'h55,1, 0,1,1,'h5A,0,'h00};
        vecs[27] = '{1,0,'h40,'h00,0, 1,1,'h35,'h66,1, 0,1,1,'h5A,0,'h00};
        vecs[28] = '{1,0,'h40,'h00,0, 1,1,'h36,'h77,1, 0,1,1,'h5A,0,'h00};
        vecs[29] = '{1,0,'h40,'h00,1, 0,0,'h00,'h00,1, 1,0,1,'h5A,0,'h00};
        vecs[30] = '{0,0,'h00,'h00,1, 0,0,'h00,'h00,1, 0,0,0,'h00,0,'h00};
        vecs[31] = '{0,0,'h00,'h00,1, 0,0,'h00,'h00,1, 0,0,1,'hD6,0,'h00};

        rst = 1'b1;
        applyStimulus(vecs[30]);
        @(posedge clk); #1;
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 8'h05; a_req_wdata = 8'h07;
        #3;
        checkOutput("reset a_req_ready", 32'(a_req_ready), 32'(0));
        checkOutput("reset ram_we", 32'(ram_we), 32'(0));
        checkOutput("reset ram_addr", 32'(ram_addr), 32'(0));
        checkOutput("reset ram_wdata", 32'(ram_wdata), 32'(0));
        checkOutput("reset a_rsp_valid", 32'(a_rsp_valid), 32'(0));
        checkOutput("reset a_rsp_rdata", 32'(a_rsp_rdata), 32'(0));
        checkOutput("reset b_rsp_valid", 32'(b_rsp_valid), 32'(0));
        checkOutput("reset b_rsp_rdata", 32'(b_rsp_rdata), 32'(0));
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        #2 rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            applyStimulus(vecs[i]);
            #3;
            checkOutput($sformatf("row%0d a_req_ready", i), 32'(a_req_ready), 32'(vecs[i].exp_ar));
            checkOutput($sformatf("row%0d b_req_ready", i), 32'(b_req_ready), 32'(vecs[i].exp_br));
            checkOutput($sformatf("row%0d a_rsp_valid", i), 32'(a_rsp_valid), 32'(vecs[i].exp_av));
            checkOutput($sformatf("row%0d b_rsp_valid", i), 32'(b_rsp_valid), 32'(vecs[i].exp_bv));
            if (vecs[i].exp_av) checkOutput($sformatf("row%0d a_rsp_rdata", i), 32'(a_rsp_rdata), 32'(vecs[i].exp_ad));
            if (vecs[i].exp_bv) checkOutput($sformatf("row%0d b_rsp_rdata", i), 32'(b_rsp_rdata), 32'(vecs[i].exp_bd));
        end

        // reset lands the cycle after a read is accepted: the response must never appear
        @(posedge clk); #1;
        applyStimulus(vecs[30]);
        a_req_valid = 1'b1; a_req_addr = 8'h10;
        #3;
        checkOutput("rstseq accept", 32'(a_req_ready), 32'(1));
        @(posedge clk); #1;
        #1 rst = 1'b1;
        #1;
        checkOutput("rstseq ready during rst", 32'(a_req_ready), 32'(0));
        checkOutput("rstseq ram_addr during rst", 32'(ram_addr), 32'(0));
        checkOutput("rstseq a_rsp_valid during rst", 32'(a_rsp_valid), 32'(0));
        a_req_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        checkOutput("rstseq a_rsp_valid after rst", 32'(a_rsp_valid), 32'(0));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #4;
            checkOutput($sformatf("rstseq no response %0d", i), 32'(a_rsp_valid), 32'(0));
        end
        @(posedge clk); #1;
        a_req_valid = 1'b1; a_req_addr = 8'h10;
        #3;
        checkOutput("rstseq reread accept", 32'(a_req_ready), 32'(1));
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        #3;
        checkOutput("rstseq reread not yet", 32'(a_rsp_valid), 32'(0));
        @(posedge clk); #4;
        checkOutput("rstseq reread valid", 32'(a_rsp_valid), 32'(1));
        checkOutput("rstseq reread data", 32'(a_rsp_rdata), 32'(8'h5A));

        // randomized traffic against the model; requesters hold until accepted
        a_acc = 1'b1;
        b_acc = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            if (!(a_req_valid && !a_acc)) begin
                a_req_valid = ($urandom_range(0, 3) != 0);
                a_req_we    = ($urandom_range(0, 2) == 0);
                a_req_addr  = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
                a_req_wdata = 8'($urandom);
            end
            if (!(b_req_valid && !b_acc)) begin
                b_req_valid = ($urandom_range(0, 3) != 0);
                b_req_we    = ($urandom_range(0, 2) == 0);
                b_req_addr  = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(0, 7));
                b_req_wdata = 8'($urandom);
            end
            a_rsp_ready = ($urandom_range(0, 3) != 0);
            b_rsp_ready = ($urandom_range(0, 3) != 0);
            #3;
            pick(ga, gb);
            e_we = 1'b0; e_addr = '0; e_wdata = '0;
            if (ga) begin
                e_we = a_req_we; e_addr = a_req_addr; e_wdata = a_req_wdata;
            end else if (gb) begin
                e_we = b_req_we; e_addr = b_req_addr; e_wdata = b_req_wdata;
            end
            checkOutput($sformatf("rnd%0d a_req_ready", n), 32'(a_req_ready), 32'(ga));
            checkOutput($sformatf("rnd%0d b_req_ready", n), 32'(b_req_ready), 32'(gb));
            checkOutput($sformatf("rnd%0d ram_we", n), 32'(ram_we), 32'(e_we));
            checkOutput($sformatf("rnd%0d ram_addr", n), 32'(ram_addr), 32'(e_addr));
            checkOutput($sformatf("rnd%0d ram_wdata", n), 32'(ram_wdata), 32'(e_wdata));
            checkOutput($sformatf("rnd%0d a_rsp_valid", n), 32'(a_rsp_valid), 32'(shown(q_a, cyc)));
            checkOutput($sformatf("rnd%0d b_rsp_valid", n), 32'(b_rsp_valid), 32'(shown(q_b, cyc)));
            if (shown(q_a, cyc)) checkOutput($sformatf("rnd%0d a_rsp_rdata", n), 32'(a_rsp_rdata), 32'(q_a[0].data));
            if (shown(q_b, cyc)) checkOutput($sformatf("rnd%0d b_rsp_rdata", n), 32'(b_rsp_rdata), 32'(q_b[0].data));
            a_acc = a_req_ready;
            b_acc = b_req_ready;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
